// File: rtl/memory_stage_pkg.sv
// Shared Y86 memory-stage definitions: instruction codes, status codes, FSM states
// and helpers that classify an icode as a memory read or write.
package memory_stage_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StHalt
    } state_e;

    function automatic logic is_write_op(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    endfunction

    function automatic logic is_read_op(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
    endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// Byte-addressed little-endian data memory: one 8-byte synchronous write port, one 8-byte
// synchronous read port sharing a single address, plus an out-of-range flag.
module data_mem #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic [63:0] addr_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    input  logic        re_i,
    input  logic        rd_clr_i,
    output logic [63:0] rdata_o,
    output logic        addr_err_o
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    // Contents survive reset; only the power-up value is zero.
    logic [7:0]    mem_q [MEM_BYTES] = '{default: 8'h00};
    logic [AW-1:0] base;
    logic [63:0]   rd_word;
    logic [63:0]   rdata_q;

    assign addr_err_o = addr_i > 64'(MEM_BYTES - 8);
    assign base       = addr_i[AW-1:0];

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 8; k++) begin
            rd_word[8*k +: 8] = mem_q[base + AW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int k = 0; k < 8; k++) begin
                mem_q[base + AW'(k)] <= wdata_i[8*k +: 8];
            end
        end
        if (rd_clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rd_word;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// Y86 memory stage: accepts one instruction from execute, performs its data-memory access
// over MEM_LATENCY cycles, and presents the result to write-back with a status code.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [3:0]  out_rA,
    output logic [3:0]  out_rB,
    output logic [63:0] out_valE,
    output logic [63:0] valM,
    output logic [2:0]  stat
);

    localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      icode_q, ra_q, rb_q;
    logic [63:0]     vale_q, addr_q, wdata_q;
    logic [2:0]      stat_q;

    logic        accept, is_mem, addr_err, go_access, last_access;
    logic        mem_we, mem_re, mem_clr;
    logic [63:0] in_addr, in_wdata, mem_addr, rdata;
    logic [2:0]  stat_in;

    assign accept    = (state_q == StIdle) && in_valid;
    assign is_mem    = is_write_op(icode) || is_read_op(icode);
    assign in_addr   = ((icode == IPOPQ) || (icode == IRET)) ? valA : valE;
    assign in_wdata  = (icode == ICALL) ? valP : valA;
    // While idle the memory checks the incoming address so stat is known at acceptance.
    assign mem_addr  = (state_q == StAccess) ? addr_q : in_addr;

    always_comb begin
        stat_in = SAOK;
        if (imem_error) begin
            stat_in = SADR;
        end else if (!instr_valid) begin
            stat_in = SINS;
        end else if (is_mem && addr_err) begin
            stat_in = SADR;
        end else if (icode == IHALT) begin
            stat_in = SHLT;
        end
    end

    assign go_access   = is_mem && (stat_in == SAOK);
    assign last_access = (state_q == StAccess) && (cnt_q == CntW'(1));
    // Reset wins over the final access edge, so an aborted write never lands.
    assign mem_we      = last_access && is_write_op(icode_q) && !reset;
    assign mem_re      = last_access && is_read_op(icode_q) && !reset;
    assign mem_clr     = reset || accept;

    data_mem #(
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .clk        (clk),
        .addr_i     (mem_addr),
        .we_i       (mem_we),
        .wdata_i    (wdata_q),
        .re_i       (mem_re),
        .rd_clr_i   (mem_clr),
        .rdata_o    (rdata),
        .addr_err_o (addr_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            icode_q <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            vale_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            stat_q  <= SAOK;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        icode_q <= icode;
                        ra_q    <= rA;
                        rb_q    <= rB;
                        vale_q  <= valE;
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata;
                        stat_q  <= stat_in;
                        state_q <= go_access ? StAccess : StDone;
                        cnt_q   <= go_access ? CntW'(MEM_LATENCY) : '0;
                    end
                end
                StAccess: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= (stat_q == SAOK) ? StIdle : StHalt;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_icode = icode_q;
    assign out_rA    = ra_q;
    assign out_rB    = rb_q;
    assign out_valE  = vale_q;
    assign valM      = rdata;
    assign stat      = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level byte-array model.
module tb_memory_stage;

    localparam int unsigned MEM_BYTES   = 1024;
    localparam int unsigned MEM_LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = '0, rA = '0, rB = '0;
    logic [63:0] valA = '0, valE = '0, valP = '0;
    logic        instr_valid = 1'b1, imem_error = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_icode, out_rA, out_rB;
    logic [63:0] out_valE, valM;
    logic [2:0]  stat;

    logic [7:0] mem_m [MEM_BYTES];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_stage #(
        .MEM_BYTES   (MEM_BYTES),
        .MEM_LATENCY (MEM_LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .valA        (valA),
        .valE        (valE),
        .valP        (valP),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_icode   (out_icode),
        .out_rA      (out_rA),
        .out_rB      (out_rB),
        .out_valE    (out_valE),
        .valM        (valM),
        .stat        (stat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Y86 status from the fetch flags, data address and icode, highest priority first.
    function automatic logic [2:0] exp_stat(input logic [3:0] ic, input logic iv, input logic ime,
                                            input logic [63:0] addr);
        logic memop;
        memop = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
                (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
        if (ime) return 3'd3;
        if (!iv) return 3'd4;
        if (memop && (addr > 64'(MEM_BYTES - 8))) return 3'd3;
        if (ic == 4'h0) return 3'd2;
        return 3'd1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stat", 64'(stat), 64'd1);
        check("rst_valM", valM, 64'd0);
        check("rst_valE", out_valE, 64'd0);
        check("rst_fields", {52'd0, out_icode, out_rA, out_rB}, 64'd0);
    endtask

    // Issues one instruction at a negedge, waits for out_valid, holds out_ready low for
    // `hold` cycles, releases it and follows an errored instruction through HALT and reset.
    task automatic run_instr(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                             input logic [63:0] p, input logic iv, input logic ime,
                             input int hold);
        logic [3:0]  ra, rb;
        logic [63:0] addr, wdata, exp_m;
        logic [2:0]  st;
        logic        wr, rd;
        int          cyc, want;
        ra    = 4'($urandom);
        rb    = 4'($urandom);
        wr    = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
        rd    = (ic == 4'h5) || (ic == 4'hB) || (ic == 4'h9);
        addr  = ((ic == 4'hB) || (ic == 4'h9)) ? a : e;
        wdata = (ic == 4'h8) ? p : a;
        st    = exp_stat(ic, iv, ime, addr);
        exp_m = '0;
        if (st == 3'd1 && wr) begin
            for (int k = 0; k < 8; k++) mem_m[int'(addr) + k] = wdata[8*k +: 8];
        end
        if (st == 3'd1 && rd) begin
            for (int k = 0; k < 8; k++) exp_m[8*k +: 8] = mem_m[int'(addr) + k];
        end
        want = ((wr || rd) && st == 3'd1) ? int'(MEM_LATENCY) + 1 : 1;

        check("idle_in_ready", 64'(in_ready), 64'd1);
        icode = ic; rA = ra; rB = rb; valA = a; valE = e; valP = p;
        instr_valid = iv; imem_error = ime; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        icode = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
        valA = {$urandom, $urandom}; valE = {$urandom, $urandom}; valP = {$urandom, $urandom};
        instr_valid = 1'($urandom); imem_error = 1'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(want));
        for (int h = 0; h <= hold; h++) begin
            check("done_out_valid", 64'(out_valid), 64'd1);
            check("done_in_ready", 64'(in_ready), 64'd0);
            check("done_stat", 64'(stat), 64'(st));
            check("done_valM", valM, exp_m);
            check("done_valE", out_valE, e);
            check("done_fields", {52'd0, out_icode, out_rA, out_rB}, {52'd0, ic, ra, rb});
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), (st == 3'd1) ? 64'd1 : 64'd0);
        if (st != 3'd1) begin
            repeat (3) @(negedge clk);
            check("halt_in_ready", 64'(in_ready), 64'd0);
            check("halt_out_valid", 64'(out_valid), 64'd0);
            check("halt_stat", 64'(stat), 64'(st));
            do_reset();
        end
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] a, e;
        for (int i = 0; i < int'(MEM_BYTES); i++) mem_m[i] = 8'h00;

        do_reset();

        // Reset during the first access cycle of a store aborts it.
        @(negedge clk);
        icode = 4'h4; valA = 64'hDEAD_BEEF_CAFE_F00D; valE = 64'h20;
        instr_valid = 1'b1; imem_error = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_stat", 64'(stat), 64'd1);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        run_instr(4'h5, 64'd0, 64'h20, 64'd0, 1'b1, 1'b0, 0);

        // Store/load round trip, including unaligned reads straddling the word.
        run_instr(4'h4, 64'h1122_3344_5566_7788, 64'h10, 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h5, 64'd0, 64'h10, 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h5, 64'd0, 64'h0F, 64'd0, 1'b1, 1'b0, 1);
        run_instr(4'h5, 64'd0, 64'h11, 64'd0, 1'b1, 1'b0, 0);

        // push then pop back-to-back; call then ret; long back-pressure.
        run_instr(4'hA, 64'd5, 64'h78, 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'hB, 64'h78, 64'h80, 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h8, 64'd0, 64'h100, 64'h0000_0000_0000_0ABC, 1'b1, 1'b0, 0);
        run_instr(4'h9, 64'h100, 64'h108, 64'd0, 1'b1, 1'b0, 4);

        // Boundary: last legal word, first illegal address, halt and invalid instructions.
        run_instr(4'h4, 64'hA5A5_0102_0304_0506, 64'(MEM_BYTES - 8), 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h5, 64'd0, 64'(MEM_BYTES - 7), 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h5, 64'd0, 64'(MEM_BYTES - 8), 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h4, 64'h1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 0);
        run_instr(4'h6, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 0);
        run_instr(4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 0);

        for (int n = 0; n < 80; n++) begin
            ic = ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
            case ($urandom_range(0, 9))
                0:       e = {$urandom, $urandom};
                1:       e = 64'(MEM_BYTES - 8 + $urandom_range(0, 2));
                default: e = 64'($urandom_range(0, 63));
            endcase
            if (ic == 4'hB || ic == 4'h9) begin
                a = ($urandom_range(0, 9) == 0) ? 64'(MEM_BYTES - 8 + $urandom_range(0, 2))
                                                : 64'($urandom_range(0, 63));
            end else begin
                a = {$urandom, $urandom};
            end
            run_instr(ic, a, e, {$urandom, $urandom}, ($urandom_range(0, 19) != 0),
                      ($urandom_range(0, 19) == 0), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_BYTES, default 1024, data-memory size in bytes (multiple of 8, at least 16).
REQ-002 Parameter MEM_LATENCY, default 2, number of ACCESS cycles per memory operation (at least 1).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  upstream handshake from execute.
REQ-006 icode, rA, rB  input  4 each  instruction fields.
REQ-007 valA, valE, valP  input  64 each  operand, ALU result, next PC.
REQ-008 instr_valid, imem_error  input  1 each  fetch status flags.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream handshake to write-back.
REQ-010 out_icode, out_rA, out_rB  output  4 each  registered copies of the accepted fields.
REQ-011 out_valE, valM  output  64 each  registered valE, and data read from memory.
REQ-012 stat  output  3  Y86 status: AOK=1, HLT=2, ADR=3, INS=4.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS, DONE, HALT; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 When IDLE and in_valid=1, the block SHALL accept the instruction and register all inputs; stat is computed at acceptance.
REQ-015 Write ops: rmmovq(4) and pushq(A) write valA at valE; call(8) writes valP at valE.
REQ-016 Read ops: mrmovq(5) reads at valE; popq(B) and ret(9) read at valA.
REQ-017 Memory words SHALL be 8 bytes, little-endian, byte-addressed, with no alignment requirement.
REQ-018 Address error: addr > MEM_BYTES-8, compared as unsigned 64-bit; the result is stat=ADR, no write, and valM=0.
REQ-019 Stat priority: imem_error→ADR > !instr_valid→INS > data address error→ADR > icode==0→HLT > AOK.
REQ-020 Non-memory icodes and errored memory ops SHALL go IDLE→DONE, asserting out_valid one cycle after acceptance.
REQ-021 Valid memory ops SHALL go IDLE→ACCESS, stay MEM_LATENCY cycles (down-counter), then go to DONE: out_valid at MEM_LATENCY+1 cycles after acceptance.
REQ-022 A memory write SHALL commit on the final ACCESS cycle edge; a read SHALL sample memory on that same edge into valM.
REQ-023 valM SHALL be 0 for non-read icodes.
REQ-024 DONE SHALL hold all outputs stable until out_ready=1; on that edge go to IDLE if stat==AOK, else to HALT.
REQ-025 HALT SHALL be sticky: in_ready=0, out_valid=0, stat held at its final value; exit only via reset.
REQ-026 A read of an address written by the immediately preceding instruction SHALL return the new data.

Reset
REQ-027 Reset SHALL take priority over all events: state=IDLE, counter=0, out_valid=0, in_ready=1 from the next cycle, stat=AOK, valM=0, out_valE=0, out_icode/rA/rB=0.
REQ-028 Reset during ACCESS SHALL abort the operation; a write not yet committed SHALL NOT occur.
REQ-029 Memory contents SHALL NOT be cleared by reset; they are zero-initialised at time zero only.

Structure
REQ-030 A shared package SHALL hold the icode constants (IHALT..IPOPQ), the stat codes, and the FSM state encoding.
REQ-031 One sub-module, data_mem, SHALL hold the byte array with one 8-byte synchronous write port and one 8-byte synchronous read port, plus an address-error output.

Verification
REQ-032 rmmovq: valA=0x1122334455667788, valE=0x10, then mrmovq at 0x10 → valM=0x1122334455667788 at cycle MEM_LATENCY+1; byte 0x10 = 0x88.
REQ-033 mrmovq with valE=MEM_BYTES-7 (1017) → stat=ADR and valM=0 one cycle after acceptance, memory unchanged, then HALT with in_ready=0.
REQ-034 pushq valA=5, valE=0x78, then popq valA=0x78 back-to-back → valM=5.
REQ-035 Hold out_ready=0 for 4 cycles in DONE → outputs stable, in_ready=0; release → IDLE the next cycle.
REQ-036 Assert reset on the first ACCESS cycle of an rmmovq to 0x20 (old value 0) → that address reads 0 afterwards, stat=AOK.
REQ-037 icode=0 → stat=HLT; instr_valid=0 → stat=INS; both cases end in HALT until reset.
